// File: rtl/booth_r4_mul_if.sv
// booth_r4_mul_if: operand/control request and result/status bundle for the Booth multiplier
interface booth_r4_mul_if #(parameter int WIDTH = 8);
    logic                 start;
    logic                 clear;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;
    modport master (
        output start, clear, signed_mode, multiplicand, multiplier,
        input  product, busy, done
    );
    modport slave (
        input  start, clear, signed_mode, multiplicand, multiplier,
        output product, busy, done
    );
endinterface

// File: rtl/booth_r4_mul.sv
// booth_r4_mul: multi-cycle radix-4 Booth multiplier, signed/unsigned, start/done handshake
module booth_r4_mul #(parameter int WIDTH = 8) (
    input logic           clk,
    input logic           reset,
    booth_r4_mul_if.slave bus
);
    localparam int EW = WIDTH + 2;
    localparam int N  = EW / 2;
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state, state_nx;
    logic [EW-1:0]      m, q;
    logic [EW:0]        a, m1, m2, addend, a_sum;
    logic               q_m1;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product;
    logic [2:0]         grp;
    logic [2*EW+1:0]    shifted;
    logic               accept, last;
    logic               m_sign, q_sign;
    assign accept = state != RUN && bus.start && !bus.clear;
    assign last   = state == RUN && count == CW'(N - 1);
    assign m_sign = bus.signed_mode & bus.multiplicand[WIDTH-1];
    assign q_sign = bus.signed_mode & bus.multiplier[WIDTH-1];
    assign grp    = {q[1:0], q_m1};
    assign m1     = {m[EW-1], m};
    assign m2     = {m, 1'b0};
    assign addend = (grp == 3'b001 || grp == 3'b010) ? m1
                  : (grp == 3'b011)                  ? m2
                  : (grp == 3'b100)                  ? -m2
                  : (grp == 3'b101 || grp == 3'b110) ? -m1
                  : '0;
    assign a_sum  = a + addend;
    // {A,Q,q_m1} shifted right arithmetically by two; q[0] and old q_m1 fall off
    assign shifted = {{2{a_sum[EW]}}, a_sum, q[EW-1:1]};
    assign bus.product = product;
    assign bus.busy    = state == RUN;
    assign bus.done    = state == DONE;
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    // next state: clear wins, a new request may start from IDLE or DONE
    always_comb begin
        state_nx = clear_or_next();
    end
    function automatic state_t clear_or_next();
        return bus.clear      ? IDLE
             : accept         ? RUN
             : state == RUN   ? (last ? DONE : RUN)
             : IDLE;
    endfunction
    // operand capture, one recode/add/shift step per RUN cycle, product on the last step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m       <= '0;
            q       <= '0;
            a       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            m     <= {{2{m_sign}}, bus.multiplicand};
            q     <= {{2{q_sign}}, bus.multiplier};
            a     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
        end else if (state == RUN && !bus.clear) begin
            a     <= shifted[2*EW+1:EW+1];
            q     <= shifted[EW:1];
            q_m1  <= shifted[0];
            count <= count + 1'b1;
            if (last) product <= shifted[2*WIDTH:1];
        end
    end
endmodule

// File: tb/tb_booth_r4_mul.sv
// tb_booth_r4_mul: scoreboard bench, directed WIDTH=8 cases plus random WIDTH=16 ops vs arithmetic model
module tb_booth_r4_mul;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] q8[$];
    logic [31:0] q16[$];
    booth_r4_mul_if #(.WIDTH(8))  b8();
    booth_r4_mul_if #(.WIDTH(16)) b16();
    booth_r4_mul #(.WIDTH(8))  d8 (.clk(clk), .reset(reset), .bus(b8));
    booth_r4_mul #(.WIDTH(16)) d16(.clk(clk), .reset(reset), .bus(b16));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [63:0] model(int w, bit sm, logic [31:0] x, logic [31:0] y);
        longint p;
        longint u = longint'(x);
        longint v = longint'(y);
        if (sm && x[w-1]) u = u - (longint'(1) << w);
        if (sm && y[w-1]) v = v - (longint'(1) << w);
        p = u * v;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (b8.done) begin
            if (q8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
            else chk("product8", 64'(b8.product), 64'(q8.pop_front()));
        end
    end
    always @(negedge clk) begin
        if (b16.done) begin
            if (q16.size() == 0) chk("unexpected_done16", 64'd1, 64'd0);
            else chk("product16", 64'(b16.product), 64'(q16.pop_front()));
        end
    end
    task automatic issue8(bit sm, logic [7:0] x, logic [7:0] y, bit push);
        @(negedge clk);
        b8.start = 1'b1;
        b8.signed_mode = sm;
        b8.multiplicand = x;
        b8.multiplier = y;
        if (push) q8.push_back(16'(model(8, sm, 32'(x), 32'(y))));
        @(negedge clk);
        b8.start = 1'b0;
        b8.signed_mode = 1'($urandom);
        b8.multiplicand = 8'($urandom);
        b8.multiplier = 8'($urandom);
    endtask
    task automatic wait8(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!b8.done && lat < 30) begin
            busy_n += int'(b8.busy);
            @(negedge clk);
            lat++;
        end
        if (!b8.done) chk("timeout8", 64'd0, 64'd1);
    endtask
    task automatic count_done8(int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            n += int'(b8.done);
        end
    endtask
    logic [16:0] dir [6] = '{
        {1'b1, 8'hF9, 8'h03}, {1'b1, 8'h80, 8'h80}, {1'b1, 8'h80, 8'h7F},
        {1'b0, 8'hFF, 8'hFF}, {1'b0, 8'h00, 8'hC8}, {1'b1, 8'hFF, 8'hFF}
    };
    logic [15:0] corner [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};
    initial begin
        int lat, bn, nd, w16;
        int dk[$];
        logic [15:0] prev, x16, y16;
        bit sm;
        reset = 1'b0;
        {b8.start, b8.clear, b8.signed_mode, b8.multiplicand, b8.multiplier} = '0;
        {b16.start, b16.clear, b16.signed_mode, b16.multiplicand, b16.multiplier} = '0;
        repeat (3) @(negedge clk);
        chk("rst_product8", 64'(b8.product), 64'd0);
        chk("rst_busy8", 64'(b8.busy), 64'd0);
        chk("rst_done8", 64'(b8.done), 64'd0);
        chk("rst_product16", 64'(b16.product), 64'd0);
        reset = 1'b1;
        issue8(1'b1, 8'd20, 8'd16, 1'b1);
        wait8(lat, bn);
        chk("latency", 64'(lat), 64'd5);
        chk("busy_cycles", 64'(bn), 64'd5);
        for (int i = 0; i < 6; i++) begin
            issue8(dir[i][16], dir[i][15:8], dir[i][7:0], 1'b1);
            wait8(lat, bn);
        end
        issue8(1'b1, 8'hF9, 8'h03, 1'b1);
        prev = 16'(model(8, 1'b1, 32'hF9, 32'h03));
        @(negedge clk);
        b8.start = 1'b1;
        b8.multiplicand = 8'h11;
        b8.multiplier = 8'h22;
        @(negedge clk);
        b8.start = 1'b0;
        wait8(lat, bn);
        chk("ignored_start_latency", 64'(lat), 64'd3);
        count_done8(10, nd);
        chk("no_extra_done", 64'(nd), 64'd0);
        issue8(1'b0, 8'd200, 8'd100, 1'b0);
        @(negedge clk);
        b8.clear = 1'b1;
        @(negedge clk);
        chk("clear_busy", 64'(b8.busy), 64'd0);
        chk("clear_done", 64'(b8.done), 64'd0);
        chk("clear_product", 64'(b8.product), 64'(prev));
        b8.clear = 1'b0;
        count_done8(10, nd);
        chk("clear_no_done", 64'(nd), 64'd0);
        chk("clear_product_hold", 64'(b8.product), 64'(prev));
        issue8(1'b1, 8'd55, 8'hFD, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrun_rst_product", 64'(b8.product), 64'd0);
        chk("midrun_rst_busy", 64'(b8.busy), 64'd0);
        chk("midrun_rst_done", 64'(b8.done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        count_done8(8, nd);
        chk("rst_no_done", 64'(nd), 64'd0);
        @(negedge clk);
        b8.start = 1'b1;
        b8.signed_mode = 1'b1;
        b8.multiplicand = 8'h9C;
        b8.multiplier = 8'h3B;
        q8.push_back(16'(model(8, 1'b1, 32'h9C, 32'h3B)));
        for (int c = 0; c < 40 && dk.size() < 3; c++) begin
            @(negedge clk);
            if (b8.done) dk.push_back(c);
            if (c == 0) begin
                b8.signed_mode = 1'b0;
                b8.multiplicand = 8'hE7;
                b8.multiplier = 8'hC3;
                q8.push_back(16'(model(8, 1'b0, 32'hE7, 32'hC3)));
            end
            if (c == 6) begin
                b8.signed_mode = 1'b1;
                b8.multiplicand = 8'h7F;
                b8.multiplier = 8'h81;
                q8.push_back(16'(model(8, 1'b1, 32'h7F, 32'h81)));
            end
            if (c == 12) b8.start = 1'b0;
        end
        b8.start = 1'b0;
        chk("b2b_done_count", 64'(dk.size()), 64'd3);
        if (dk.size() == 3) begin
            chk("b2b_first", 64'(dk[0]), 64'd5);
            chk("b2b_gap1", 64'(dk[1] - dk[0]), 64'd6);
            chk("b2b_gap2", 64'(dk[2] - dk[1]), 64'd6);
        end
        for (int i = 0; i < 1000; i++) begin
            x16 = (i < 16) ? corner[i % 4] : 16'($urandom);
            y16 = (i < 16) ? corner[i / 4] : 16'($urandom);
            sm = (i < 16) ? 1'b1 : 1'($urandom);
            if (i >= 16 && i < 32) sm = 1'b0;
            if (i >= 16 && i < 32) x16 = corner[i % 4];
            if (i >= 16 && i < 32) y16 = corner[(i - 16) / 4];
            @(negedge clk);
            b16.start = 1'b1;
            b16.signed_mode = sm;
            b16.multiplicand = x16;
            b16.multiplier = y16;
            q16.push_back(32'(model(16, sm, 32'(x16), 32'(y16))));
            @(negedge clk);
            b16.start = 1'b0;
            b16.multiplicand = 16'($urandom);
            b16.multiplier = 16'($urandom);
            w16 = 0;
            while (!b16.done && w16 < 40) begin
                @(negedge clk);
                w16++;
            end
            if (!b16.done) chk("timeout16", 64'd0, 64'd1);
        end
        repeat (3) @(negedge clk);
        chk("pending8", 64'(q8.size()), 64'd0);
        chk("pending16", 64'(q16.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
